// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem req/ack, decode valid/ready and redirect bundle of the fetch stage.
interface instr_fetch_if #(parameter int ADDR_W = 32);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              misalign_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4, misalign_err,
        input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4, misalign_err,
        output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, imem req/ack fetch and valid/ready hand-off to decode with jal/jalr redirect.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects set a sticky error and halt the unit.
module instr_fetch_unit #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]       NOP_WORD     = 32'h0000_0013
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);
`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALT} state_t;
`else
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d, pc_plus4_q, pc_plus4_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] tgt;
    logic              redir;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic err_q, err_d, pend_q, pend_d, bad;
    assign bad   = bus.redirect_valid && bus.redirect_target[1:0] != 2'b00;
    assign redir = bus.redirect_valid && !bad;
    assign tgt   = bus.redirect_target;
    assign bus.misalign_err = err_q;

    // pend_q: a halt is waiting for the outstanding ack to drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end
`else
    assign redir = bus.redirect_valid;
    assign tgt   = bus.redirect_target & ~ADDR_W'(3);
    assign bus.misalign_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_VECTOR;
            req_addr_q <= RESET_VECTOR;
            instr_q    <= NOP_WORD;
            instr_pc_q <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        err_d      = err_q;
        pend_d     = pend_q;
`endif
        case (state_q)
            FETCH: begin
                if (redir) begin
                    pc_d = tgt;
                    if (!bus.imem_ack) begin
                        req_addr_d = pc_q;
                        state_d    = DRAIN;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                else if (bad) begin
                    err_d = 1'b1;
                    if (bus.imem_ack) state_d = HALT;
                    else begin
                        req_addr_d = pc_q;
                        pend_d     = 1'b1;
                        state_d    = DRAIN;
                    end
                end
`endif
                else if (bus.imem_ack) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    pc_plus4_d = pc_q + ADDR_W'(4);
                    pc_d       = pc_q + ADDR_W'(4);
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (redir) begin
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                    pc_d    = tgt;
                    state_d = FETCH;
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                else if (bad) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                    state_d = HALT;
                end
`endif
                else if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (pend_q) begin
                    if (bus.imem_ack) state_d = HALT;
                end else if (bad) begin
                    err_d  = 1'b1;
                    pend_d = 1'b1;
                    if (bus.imem_ack) state_d = HALT;
                end else
`endif
                begin
                    if (redir) pc_d = tgt;
                    if (bus.imem_ack) state_d = FETCH;
                end
            end
            default: ;
        endcase
    end

    // DRAIN keeps presenting the stale address so the request stays stable until its ack
    always_comb begin
        bus.imem_req  = state_q == FETCH || state_q == DRAIN;
        bus.imem_addr = state_q == DRAIN ? req_addr_q : pc_q;
    end

    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.pc_plus4    = pc_plus4_q;
endmodule
